// File: rtl/imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory arbiter slice.
//   owner_e       : which requester currently holds the memory
//   DEFAULT_AW    : default word-address width toward memory (8192 words)
//   DEFAULT_MAX_BURST : default consecutive-grant limit under contention
//   WORD_SHIFT    : byte-to-word address shift
//   GNT_FETCH / GNT_LOAD : bit positions inside the arbiter grant vector
//   burst_inc()   : saturating burst counter increment
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int DEFAULT_AW        = 13;
  localparam int DEFAULT_MAX_BURST = 8;
  localparam int WORD_SHIFT        = 2;

  localparam int GNT_FETCH = 0;
  localparam int GNT_LOAD  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } owner_e;

  // Count one more consecutive grant, never past the burst limit.
  function automatic logic [7:0] burst_inc(input logic [7:0] cnt,
                                           input logic [7:0] max_burst);
    if (cnt >= max_burst) begin
      burst_inc = max_burst;
    end else begin
      burst_inc = cnt + 8'd1;
    end
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch port, loader port and memory port of imem_arbiter.
//   slave  : arbiter view (takes requests, drives grants and memory controls)
//   master : environment view (requesters plus the memory array)
// Fetch  : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
// Loader : l_req, l_addr, l_wdata -> l_gnt
// Memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle latency)
// With IMEM_BOUNDS_CHECK_EN defined, f_err and l_err are added.
// -----------------------------------------------------------------------------
interface imem_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 13
);

  logic            f_req;
  logic [XLEN-1:0] f_addr;
  logic            f_gnt;
  logic            f_rvalid;
  logic [31:0]     f_rdata;

  logic            l_req;
  logic [XLEN-1:0] l_addr;
  logic [31:0]     l_wdata;
  logic            l_gnt;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic            f_err;
  logic            l_err;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output f_err, l_err
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  f_err, l_err
  );
`else
  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`endif

endinterface

// File: rtl/imem_arbiter_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
// Two-requester arbiter with bounded bursts. Holds the current owner and the
// number of consecutive grants it has received. Under contention the owner
// keeps the memory until it has had MAX_BURST grants in a row, then the other
// requester takes over. From idle, the loader wins a tie.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   req  : request vector, [0] = fetch, [1] = loader
//   gnt  : one-hot (or zero) grant vector, same bit order; combinational
// -----------------------------------------------------------------------------
module rr_burst_arbiter
  import imem_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_e     owner_r;
  owner_e     owner_nxt_s;
  logic [7:0] burst_cnt_r;
  logic [7:0] burst_cnt_nxt_s;
  logic [1:0] gnt_s;

  // Owner and burst counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r     <= IDLE;
      burst_cnt_r <= 8'd0;
    end else begin
      owner_r     <= owner_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // Grant decision and next owner/burst state.
  always_comb begin
    gnt_s           = 2'b00;
    owner_nxt_s     = IDLE;
    burst_cnt_nxt_s = 8'd0;

    // Grants are forced low while reset is held so no access leaks out.
    if (!rst) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01: gnt_s = 2'b01;
        2'b10: gnt_s = 2'b10;
        2'b11: begin
          case (owner_r)
            FETCH:   gnt_s = (burst_cnt_r < MAX_B) ? 2'b01 : 2'b10;
            LOAD:    gnt_s = (burst_cnt_r < MAX_B) ? 2'b10 : 2'b01;
            default: gnt_s = 2'b10;
          endcase
        end
        default: gnt_s = 2'b00;
      endcase
    end

    case (gnt_s)
      2'b01: begin
        owner_nxt_s     = FETCH;
        burst_cnt_nxt_s = (owner_r == FETCH) ? burst_inc(burst_cnt_r, MAX_B) : 8'd1;
      end
      2'b10: begin
        owner_nxt_s     = LOAD;
        burst_cnt_nxt_s = (owner_r == LOAD) ? burst_inc(burst_cnt_r, MAX_B) : 8'd1;
      end
      default: begin
        owner_nxt_s     = IDLE;
        burst_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares one single-port instruction memory between the core fetch port
// (read only) and the program-loader port (write only). Grants are
// combinational; read data comes back exactly one cycle after a fetch grant.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : imem_arbiter_if.slave carrying the fetch, loader and memory ports
// Build option IMEM_BOUNDS_CHECK_EN: addresses at or above 4<<AW are still
// handshaken but never reach memory; a fetch returns zero data with f_err,
// a loader write is dropped with l_err. Without it, high address bits are
// simply truncated so addresses wrap.
// -----------------------------------------------------------------------------
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int AW        = DEFAULT_AW,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic            clk,
  input  logic            rst,
  imem_arbiter_if.slave   bus
);

  logic [1:0]    gnt_s;
  logic [AW-1:0] f_word_s;
  logic [AW-1:0] l_word_s;
  logic          f_oob_s;
  logic          l_oob_s;
  logic          f_drop_s;
  logic          l_drop_s;

  logic          mem_en_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   mem_wdata_s;

  logic          rvalid_r;
  logic          ferr_r;

  // Byte address bits [1:0] carry no meaning for word-wide memory.
  logic          unused_lsb_s;
  assign unused_lsb_s = ^{bus.f_addr[WORD_SHIFT-1:0], bus.l_addr[WORD_SHIFT-1:0]};

  assign f_word_s = bus.f_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
  assign l_word_s = bus.l_addr[AW+WORD_SHIFT-1:WORD_SHIFT];

  // Out of range means any byte-address bit above the memory span is set.
  assign f_oob_s = (bus.f_addr >> (AW + WORD_SHIFT)) != '0;
  assign l_oob_s = (bus.l_addr >> (AW + WORD_SHIFT)) != '0;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign f_drop_s = f_oob_s;
  assign l_drop_s = l_oob_s;
`else
  logic unused_oob_s;
  assign unused_oob_s = f_oob_s ^ l_oob_s;
  assign f_drop_s     = 1'b0;
  assign l_drop_s     = 1'b0;
`endif

  rr_burst_arbiter #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.l_req, bus.f_req}),
    .gnt (gnt_s)
  );

  // Memory port mux: route the granted requester, zeros otherwise.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = 32'd0;
    if (gnt_s[GNT_LOAD] && !l_drop_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b1;
      mem_addr_s  = l_word_s;
      mem_wdata_s = bus.l_wdata;
    end else if (gnt_s[GNT_FETCH] && !f_drop_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b0;
      mem_addr_s  = f_word_s;
      mem_wdata_s = 32'd0;
    end else begin
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = 32'd0;
    end
  end

  // Read-return tracking: one-cycle valid, plus whether that fetch was dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_r <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      rvalid_r <= gnt_s[GNT_FETCH];
      ferr_r   <= gnt_s[GNT_FETCH] & f_drop_s;
    end
  end

  assign bus.f_gnt     = gnt_s[GNT_FETCH];
  assign bus.l_gnt     = gnt_s[GNT_LOAD];
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.f_rvalid  = rvalid_r;
  // A dropped fetch never touched memory, so its return slot carries zero.
  assign bus.f_rdata   = (rvalid_r && !ferr_r) ? bus.mem_rdata : 32'd0;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign bus.f_err = ferr_r;
  assign bus.l_err = gnt_s[GNT_LOAD] & l_drop_s;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port instruction memory between two requesters.
  - Core fetch port: read only.
  - Program-loader port: write only, fed by UART/debug.
- Sits between the IF stage and the memory array or BSRAM.
- Drives memory address, enable and write controls, and returns fetch data with one-cycle read latency.
- Bounded-burst fairness keeps a long load from starving fetch, and keeps continuous fetch from starving the loader.

Parameters:
- XLEN, 32: width of byte addresses on the requester ports.
- AW, 13: word-address width toward memory (8192 words).
- MAX_BURST, 8: maximum consecutive grants to one requester while the other is pending. Legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- f_req  input  1  fetch read request
- f_addr  input  XLEN  fetch byte address
- f_gnt  output  1  fetch accepted this cycle
- f_rvalid  output  1  fetch data valid
- f_rdata  output  32  fetch instruction word
- l_req  input  1  loader write request
- l_addr  input  XLEN  loader byte address
- l_wdata  input  32  loader write word
- l_gnt  output  1  loader write accepted this cycle
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory word address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Registered state:
  - owner: IDLE / FETCH / LOAD.
  - burst_cnt: 8 bits.
  - rvalid_q.
- Reset (rst=0, asynchronous):
  - owner=IDLE, burst_cnt=0, rvalid_q=0.
  - All outputs are 0 while in reset.
- Grant is combinational from f_req, l_req, owner and burst_cnt. At most one grant per cycle.
  - Only one requester asserts req: that requester is granted.
  - Both assert req, owner=IDLE: loader wins.
  - Both assert req, owner=X, burst_cnt<MAX_BURST: X is granted again.
  - Both assert req, owner=X, burst_cnt==MAX_BURST: the other requester is granted.
  - Neither asserts req: no grant.
- Registered state update each clock edge:
  - Grant to the same requester as owner: burst_cnt increments, saturating at MAX_BURST.
  - Grant to a different requester: owner switches and burst_cnt=1.
  - No grant: owner=IDLE, burst_cnt=0.
- Memory drive:
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt.
  - mem_addr = granted address [AW+1:2].
  - mem_wdata = l_wdata.
  - All mem outputs are 0 when there is no grant.
- Address rules:
  - Byte address bits [1:0] are ignored (no misalignment trap).
  - Bits above AW+1 are truncated, so addresses wrap.
- Read return:
  - rvalid_q <= f_gnt.
  - f_rvalid = rvalid_q.
  - f_rdata = mem_rdata when f_rvalid, else 0.
  - Latency is exactly 1 cycle after f_gnt; back-to-back grants give back-to-back data.
- Requester obligations: hold req and addr/data stable until gnt. A request dropped before gnt is legal; no access occurs.
- Write-then-read ordering:
  - A loader write at cycle N followed by a fetch grant at cycle N+1 to the same address returns the new word.
  - Write-first behaviour is required of the memory.
- Reset asserted with rvalid_q=1: the pending return is discarded and f_rvalid is not asserted after reset release.

Optional Feature:
- Macro: IMEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds outputs f_err and l_err, each 1 bit.
  - A request with an address at or above 4<<AW is still granted (handshake completes), but mem_en stays 0.
  - Fetch case: f_rvalid pulses next cycle with f_rdata=0 and f_err=1 in that same cycle.
  - Loader case: l_err=1 in the grant cycle and the write is dropped.
  - Both error outputs are 0 at reset.
- Undefined: the error ports are absent and out-of-range addresses wrap by truncation.

Decomposition:
- Package imem_pkg:
  - owner encoding: IDLE=2'd0, FETCH=2'd1, LOAD=2'd2.
  - Default MAX_BURST and AW constants.
  - Byte-to-word shift constant of 2.
- Sub-module rr_burst_arbiter: two-requester arbiter holding owner and burst_cnt, outputs gnt[1:0].
- imem_arbiter adds memory muxing, the read-return register and the bounds-check logic.

Test Plan:
- Reset with f_req=1: f_gnt=0, mem_en=0 during reset; the first grant occurs the cycle after release.
- Single fetch, f_addr=0x8, memory word 2=0x06100293: f_gnt in cycle N, mem_addr=2; f_rvalid=1, f_rdata=0x06100293 in N+1.
- Loader writes 0xDEADBEEF at 0x10, then fetch of 0x10 next cycle: mem_we=1, mem_addr=4; f_rdata=0xDEADBEEF.
- Both requesting continuously, MAX_BURST=8: first 8 grants go to loader, next 8 to fetch, alternating; no requester waits more than 8 cycles.
- Assert rst mid-stream while f_rvalid is pending: f_rvalid=0 immediately and stays 0 after release until a new grant.
- With IMEM_BOUNDS_CHECK_EN and AW=13, fetch of 0x8000: mem_en=0, f_rvalid=1, f_rdata=0, f_err=1 one cycle after grant.
- Without IMEM_BOUNDS_CHECK_EN, same fetch: mem_addr=0 (wrap).
